// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU command driver: opcodes, FSM states,
// the drive-pin bundle and command decode helpers.
package alsu_pkg;

    localparam int ALSU_LAT_DEFAULT = 2;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_XOR   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_SHIFT = 3'd4;
    localparam logic [2:0] OP_ROT   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRELOAD = 3'd1,
        S_ISSUE   = 3'd2,
        S_DRAIN   = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] opcode;
        logic       cin;
        logic       serial_in;
        logic       direction;
        logic       red_op_a;
        logic       red_op_b;
        logic       bypass_a;
        logic       bypass_b;
    } alsu_drv_t;

    typedef struct packed {
        alsu_drv_t  drv;
        logic [2:0] rpt;
    } cmd_t;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SHIFT) || (op == OP_ROT);
    endfunction

    // Bypass overrides everything in the ALSU, so it masks both error sources.
    function automatic logic cmd_invalid(input alsu_drv_t d);
        logic no_bypass;
        logic bad_op;
        logic bad_red;
        no_bypass = !d.bypass_a && !d.bypass_b;
        bad_op    = (d.opcode[2:1] == 2'b11);
        bad_red   = (d.opcode >= OP_ADD) && (d.opcode <= OP_ROT) && (d.red_op_a || d.red_op_b);
        return no_bypass && (bad_op || bad_red);
    endfunction

    function automatic logic needs_preload(input alsu_drv_t d);
        return is_shift_op(d.opcode) && !d.bypass_a && !d.bypass_b;
    endfunction

endpackage

// File: rtl/alsu_driver.sv
// Command-side initiator for the registered ALSU: one command per handshake,
// optional output-register preload for shift/rotate, timed result capture.
module alsu_driver
    import alsu_pkg::*;
#(
    parameter int ALSU_LAT = ALSU_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_a,
    input  logic [2:0]  cmd_b,
    input  logic [2:0]  cmd_opcode,
    input  logic        cmd_cin,
    input  logic        cmd_serial_in,
    input  logic        cmd_direction,
    input  logic        cmd_red_op_a,
    input  logic        cmd_red_op_b,
    input  logic        cmd_bypass_a,
    input  logic        cmd_bypass_b,
    input  logic [2:0]  cmd_repeat,
    output logic [2:0]  alsu_a,
    output logic [2:0]  alsu_b,
    output logic [2:0]  alsu_opcode,
    output logic        alsu_cin,
    output logic        alsu_serial_in,
    output logic        alsu_direction,
    output logic        alsu_red_op_a,
    output logic        alsu_red_op_b,
    output logic        alsu_bypass_a,
    output logic        alsu_bypass_b,
    input  logic [5:0]  alsu_out,
    input  logic [15:0] alsu_leds,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [5:0]  rsp_out,
    output logic [15:0] rsp_leds,
    output logic        rsp_err,
    output logic [2:0]  state_dbg
);

    // Handshakes: a transfer happens on the rising edge where valid && ready;
    // cmd_ready is high only in IDLE, rsp_valid only in RESP, and rsp_* hold
    // steady from rsp_valid rising until the transfer edge.

    state_t     state, next_state;
    cmd_t       cmd_q, cmd_in, cmd_src;
    alsu_drv_t  drive_d, drive_q;
    logic [2:0] step_cnt;
    logic [3:0] lat_cnt;
    logic       ready_q;
    logic       accept;

    assign accept = cmd_valid && ready_q;

    always_comb begin
        cmd_in.drv.a         = cmd_a;
        cmd_in.drv.b         = cmd_b;
        cmd_in.drv.opcode    = cmd_opcode;
        cmd_in.drv.cin       = cmd_cin;
        cmd_in.drv.serial_in = cmd_serial_in;
        cmd_in.drv.direction = cmd_direction;
        cmd_in.drv.red_op_a  = cmd_red_op_a;
        cmd_in.drv.red_op_b  = cmd_red_op_b;
        cmd_in.drv.bypass_a  = cmd_bypass_a;
        cmd_in.drv.bypass_b  = cmd_bypass_b;
        cmd_in.rpt           = cmd_repeat;
    end

    // Drive registers are loaded on the accept edge itself, so the first drive
    // comes straight from the command inputs rather than the latched copy.
    assign cmd_src = (state == S_IDLE) ? cmd_in : cmd_q;

    always_comb begin
        next_state = state;
        drive_d    = '0;
        case (state)
            S_IDLE:    if (accept) next_state = needs_preload(cmd_in.drv) ? S_PRELOAD : S_ISSUE;
            S_PRELOAD: next_state = S_ISSUE;
            S_ISSUE:   if (step_cnt == 3'd0) next_state = S_DRAIN;
            S_DRAIN:   if (lat_cnt == 4'd0) next_state = S_RESP;
            S_RESP:    if (rsp_ready) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
        case (next_state)
            S_PRELOAD: begin
                drive_d.a        = cmd_src.drv.a;
                drive_d.bypass_a = 1'b1;
            end
            S_ISSUE:   drive_d = cmd_src.drv;
            default:   drive_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ready_q  <= 1'b0;
            cmd_q    <= '0;
            drive_q  <= '0;
            step_cnt <= 3'd0;
            lat_cnt  <= 4'd0;
            rsp_out  <= 6'd0;
            rsp_leds <= 16'd0;
            rsp_err  <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == S_IDLE);
            drive_q <= drive_d;
            if (accept) begin
                cmd_q    <= cmd_in;
                step_cnt <= 3'd0;
            end else if (state == S_PRELOAD) begin
                step_cnt <= cmd_q.rpt;
            end else if ((state == S_ISSUE) && (step_cnt != 3'd0)) begin
                step_cnt <= step_cnt - 3'd1;
            end
            // DRAIN lasts ALSU_LAT cycles so the last issued op is on alsu_out.
            if ((state == S_ISSUE) && (next_state == S_DRAIN)) begin
                lat_cnt <= 4'(ALSU_LAT - 1);
            end else if ((state == S_DRAIN) && (lat_cnt != 4'd0)) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if ((state == S_DRAIN) && (lat_cnt == 4'd0)) begin
                rsp_out  <= alsu_out;
                rsp_leds <= alsu_leds;
                rsp_err  <= cmd_invalid(cmd_q.drv);
            end
        end
    end

    assign cmd_ready      = ready_q;
    assign rsp_valid      = (state == S_RESP);
    assign state_dbg      = state;
    assign alsu_a         = drive_q.a;
    assign alsu_b         = drive_q.b;
    assign alsu_opcode    = drive_q.opcode;
    assign alsu_cin       = drive_q.cin;
    assign alsu_serial_in = drive_q.serial_in;
    assign alsu_direction = drive_q.direction;
    assign alsu_red_op_a  = drive_q.red_op_a;
    assign alsu_red_op_b  = drive_q.red_op_b;
    assign alsu_bypass_a  = drive_q.bypass_a;
    assign alsu_bypass_b  = drive_q.bypass_b;

endmodule

// File: tb/tb_alsu_driver.sv
// Bench for alsu_driver: a registered ALSU (FULL_ADDER on, two-stage) lives
// in the bench, results are predicted from the command alone.
module tb_alsu_driver;
    import alsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [2:0]  cmd_a = 3'd0, cmd_b = 3'd0, cmd_opcode = 3'd0, cmd_repeat = 3'd0;
    logic        cmd_cin = 1'b0, cmd_serial_in = 1'b0, cmd_direction = 1'b0;
    logic        cmd_red_op_a = 1'b0, cmd_red_op_b = 1'b0, cmd_bypass_a = 1'b0, cmd_bypass_b = 1'b0;
    logic [2:0]  alsu_a, alsu_b, alsu_opcode;
    logic        alsu_cin, alsu_serial_in, alsu_direction;
    logic        alsu_red_op_a, alsu_red_op_b, alsu_bypass_a, alsu_bypass_b;
    logic [5:0]  alsu_out;
    logic [15:0] alsu_leds;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [5:0]  rsp_out;
    logic [15:0] rsp_leds;
    logic [2:0]  state_dbg;

    // ---------------- clock / reset block
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    alsu_driver #(.ALSU_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode),
        .cmd_cin(cmd_cin), .cmd_serial_in(cmd_serial_in), .cmd_direction(cmd_direction),
        .cmd_red_op_a(cmd_red_op_a), .cmd_red_op_b(cmd_red_op_b),
        .cmd_bypass_a(cmd_bypass_a), .cmd_bypass_b(cmd_bypass_b),
        .cmd_repeat(cmd_repeat),
        .alsu_a(alsu_a), .alsu_b(alsu_b), .alsu_opcode(alsu_opcode),
        .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in), .alsu_direction(alsu_direction),
        .alsu_red_op_a(alsu_red_op_a), .alsu_red_op_b(alsu_red_op_b),
        .alsu_bypass_a(alsu_bypass_a), .alsu_bypass_b(alsu_bypass_b),
        .alsu_out(alsu_out), .alsu_leds(alsu_leds),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_leds(rsp_leds), .rsp_err(rsp_err),
        .state_dbg(state_dbg)
    );

    // ---------------- ALSU environment: input register stage, then output stage
    logic [2:0]  r_a = 3'd0, r_b = 3'd0, r_op = 3'd0;
    logic        r_cin = 1'b0, r_si = 1'b0, r_dir = 1'b0, r_ra = 1'b0, r_rb = 1'b0, r_ba = 1'b0, r_bb = 1'b0;
    logic [5:0]  m_out = 6'd0;
    logic [15:0] m_leds = 16'd0;
    logic        m_bad;
    assign alsu_out  = m_out;
    assign alsu_leds = m_leds;
    assign m_bad = (r_op >= 3'd6) || ((r_op >= 3'd2) && (r_op <= 3'd5) && (r_ra || r_rb));

    always @(posedge clk) begin
        r_a <= alsu_a; r_b <= alsu_b; r_op <= alsu_opcode; r_cin <= alsu_cin;
        r_si <= alsu_serial_in; r_dir <= alsu_direction; r_ra <= alsu_red_op_a;
        r_rb <= alsu_red_op_b; r_ba <= alsu_bypass_a; r_bb <= alsu_bypass_b;
    end

    always @(posedge clk) begin
        m_leds <= 16'd0;
        if (r_ba)       m_out <= {3'b000, r_a};
        else if (r_bb)  m_out <= {3'b000, r_b};
        else if (m_bad) begin
            m_out  <= 6'd0;
            m_leds <= ~m_leds;
        end else begin
            case (r_op)
                3'd0: m_out <= r_ra ? {5'd0, &r_a} : r_rb ? {5'd0, &r_b} : {3'd0, r_a & r_b};
                3'd1: m_out <= r_ra ? {5'd0, ^r_a} : r_rb ? {5'd0, ^r_b} : {3'd0, r_a ^ r_b};
                3'd2: m_out <= {3'd0, r_a} + {3'd0, r_b} + {5'd0, r_cin};
                3'd3: m_out <= {3'd0, r_a} * {3'd0, r_b};
                3'd4: m_out <= r_dir ? {m_out[4:0], r_si} : {r_si, m_out[5:1]};
                default: m_out <= r_dir ? {m_out[4:0], m_out[5]} : {m_out[0], m_out[5:1]};
            endcase
        end
    end

    // ---------------- scoreboard
    int total = 0;
    int bad = 0;
    logic [22:0] exp_q[$];
    int acc_c;
    int exp_lat;
    int last_wait;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Result of a command from the ALSU rules: {err, out[5:0], leds[15:0]}.
    function automatic logic [22:0] ref_model(input int a, b, op, cin, si, dir, ra, rb, ba, bb, rpt);
        int v;
        int steps;
        bit err;
        bit pre;
        pre   = (op == 4 || op == 5) && ba == 0 && bb == 0;
        steps = pre ? rpt + 1 : 1;
        err   = (ba == 0 && bb == 0) && (op >= 6 || (op >= 2 && op <= 5 && (ra != 0 || rb != 0)));
        v = 0;
        if (ba != 0)      v = a;
        else if (bb != 0) v = b;
        else if (!err) begin
            case (op)
                0: v = (ra != 0) ? int'(a == 7) : (rb != 0) ? int'(b == 7) : (a & b);
                1: v = (ra != 0) ? $countones(a) % 2 : (rb != 0) ? $countones(b) % 2 : (a ^ b);
                2: v = a + b + cin;
                3: v = a * b;
                4: begin
                    v = a;
                    for (int k = 0; k < steps; k++) v = (dir != 0) ? (v * 2 + si) % 64 : si * 32 + v / 2;
                end
                default: begin
                    v = a;
                    for (int k = 0; k < steps; k++) v = (dir != 0) ? (v * 2) % 64 + v / 32 : (v % 2) * 32 + v / 2;
                end
            endcase
        end
        return {err, 6'(v), ((err && (steps % 2 == 1)) ? 16'hFFFF : 16'h0000)};
    endfunction

    // ---------------- driver tasks
    task automatic send_cmd(input int a, b, op, cin, si, dir, ra, rb, ba, bb, rpt);
        bit pre;
        pre = (op == 4 || op == 5) && ba == 0 && bb == 0;
        exp_q.push_back(ref_model(a, b, op, cin, si, dir, ra, rb, ba, bb, rpt));
        exp_lat = pre ? 4 + rpt : 3;
        @(negedge clk);
        cmd_a = 3'(a); cmd_b = 3'(b); cmd_opcode = 3'(op); cmd_cin = 1'(cin);
        cmd_serial_in = 1'(si); cmd_direction = 1'(dir); cmd_red_op_a = 1'(ra);
        cmd_red_op_b = 1'(rb); cmd_bypass_a = 1'(ba); cmd_bypass_b = 1'(bb);
        cmd_repeat = 3'(rpt); cmd_valid = 1'b1;
        last_wait = 0;
        while (!cmd_ready && last_wait < 50) begin
            @(negedge clk);
            last_wait++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        acc_c = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        {cmd_a, cmd_b, cmd_opcode} = 9'($urandom);
        {cmd_cin, cmd_serial_in, cmd_direction, cmd_red_op_a, cmd_red_op_b, cmd_bypass_a, cmd_bypass_b} = 7'($urandom);
        cmd_repeat = 3'($urandom);
    endtask

    task automatic get_rsp(input string tag, input int hold);
        int n;
        logic [22:0] e;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 80) begin
            @(negedge clk);
            n++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 23'd0;
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        if (!rsp_valid) return;
        check({tag, "_latency"}, 32'(cyc - acc_c - 1), 32'(exp_lat));
        check({tag, "_out"}, 32'(rsp_out), 32'(e[21:16]));
        check({tag, "_err"}, 32'(rsp_err), 32'(e[22]));
        check({tag, "_leds"}, 32'(rsp_leds), 32'(e[15:0]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, 32'({rsp_valid, cmd_ready, rsp_err, rsp_out, rsp_leds}),
                  32'({1'b1, 1'b0, e[22], e[21:16], e[15:0]}));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({cmd_ready, rsp_valid, rsp_err, alsu_a, alsu_b, alsu_opcode, alsu_cin, alsu_serial_in,
                    alsu_direction, alsu_red_op_a, alsu_red_op_b, alsu_bypass_a, alsu_bypass_b});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed then random sequence
    initial begin
        #12;
        check("reset_outs", all_outs(), 32'd0);
        check("reset_rsp", 32'({rsp_out, rsp_leds}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(cmd_ready), 32'd1);

        // args: a b op cin si dir ra rb ba bb rpt
        send_cmd(3, 5, 2, 1, 0, 0, 0, 0, 0, 0, 0);  get_rsp("add", 0);
        send_cmd(7, 7, 3, 0, 0, 0, 0, 0, 0, 0, 0);  get_rsp("mul", 0);
        send_cmd(6, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("b2b_wait", 32'(last_wait), 32'd0);
        get_rsp("xor", 0);
        send_cmd(5, 0, 4, 0, 1, 1, 0, 0, 0, 0, 2);  get_rsp("shift", 0);
        send_cmd(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);  get_rsp("rot", 0);
        send_cmd(2, 6, 4, 0, 1, 1, 0, 0, 0, 1, 5);  get_rsp("bypass_b", 0);
        send_cmd(4, 2, 6, 0, 0, 0, 0, 0, 0, 0, 0);  get_rsp("op6", 0);
        send_cmd(3, 5, 2, 1, 0, 0, 1, 0, 0, 0, 0);  get_rsp("add_red", 0);
        send_cmd(5, 6, 3, 0, 0, 0, 0, 0, 0, 0, 0);  get_rsp("hold5", 5);
        send_cmd(6, 5, 5, 0, 0, 1, 0, 0, 0, 0, 7);  get_rsp("rot7", 0);
        rsp_ready = 1'b1;
        send_cmd(4, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0);  get_rsp("early_ready", 0);

        // Reset while a repeat=7 shift is still issuing.
        send_cmd(3, 0, 4, 0, 1, 1, 0, 0, 0, 0, 7);
        repeat (3) @(negedge clk);
        check("mid_state", 32'(state_dbg), 32'(S_ISSUE));
        rst = 1'b1;
        #1;
        check("mid_reset_outs", all_outs(), 32'd0);
        check("mid_reset_rsp", 32'({rsp_out, rsp_leds}), 32'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_ready", 32'({cmd_ready, rsp_valid}), 32'b10);

        for (int i = 0; i < 40; i++) begin
            int op, ba, bb, ra, rb, hold;
            bit early;
            op = $urandom_range(0, 7);
            ba = int'($urandom_range(0, 7) == 0);
            bb = int'($urandom_range(0, 7) == 0);
            ra = int'($urandom_range(0, 5) == 0);
            rb = int'($urandom_range(0, 5) == 0);
            early = ($urandom_range(0, 3) == 0);
            hold = early ? 0 : $urandom_range(0, 3);
            if (early) rsp_ready = 1'b1;
            send_cmd($urandom_range(0, 7), $urandom_range(0, 7), op, $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 1), ra, rb, ba, bb, $urandom_range(0, 7));
            get_rsp("rand", hold);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
